spi_mem_slave: RTL and testbench

SPI slave that turns 72-bit serial command frames into single-word transactions on the data port of the tightly-coupled memory (TCM). It sits between an external SPI master and the TCM data port, which it drives when the SPI path owns memory. Write frames store a 32-bit word; read frames fetch a word that is shifted back on miso during the next frame. All logic runs on clk; sclk, cs and mosi are sampled as data.

---
 rtl/spi_mem_slave.sv | 193 +++++++++++++++++++
 tb/tb_spi_mem_slave.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_slave.sv
// SPI slave bridging 72-bit LSB-first command frames to single-word TCM data-port reads/writes.
// Latency: start_flag and the TCM request appear ~SYNC_STAGES+2 clk after the 72nd sclk fall; read data returns on miso next frame.
// Backpressure: request held stable until mem_accept; frames completing while a transaction is in flight are dropped.
module spi_mem_slave #(
  parameter int FRAME_BITS  = 72,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sclk,
  input  logic        cs,
  input  logic        mosi,
  output logic        miso,
  output logic        start_flag,
  input  logic [31:0] data_rd_i,
  output logic        mem_d_rd_o,
  output logic [31:0] data_adr_o,
  output logic [31:0] data_wr_o,
  output logic [3:0]  data_wr_en_o,
  input  logic        mem_ack,
  input  logic        mem_accept
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [SYNC_STAGES-1:0]  r_sclk_sync;
  logic [SYNC_STAGES-1:0]  r_cs_sync;
  logic [SYNC_STAGES-1:0]  r_mosi_sync;
  logic                    r_sclk_prev;

  logic [CNT_W-1:0]        r_bit_cnt;
  logic [FRAME_BITS-2:0]   r_frame;
  logic [31:0]             r_tx;
  logic [31:0]             r_rd_buf;

  logic                    r_is_rd;
  logic [31:0]             r_adr;
  logic [31:0]             r_wdat;
  logic                    r_start;

  logic                    w_sclk_s;
  logic                    w_cs_s;
  logic                    w_mosi_s;
  logic                    w_sclk_fall;
  logic                    w_last_bit;
  logic [FRAME_BITS-1:0]   w_frame;
  logic [7:0]              w_op;
  logic                    w_op_vld;
  logic                    w_start;
  logic                    w_capture;

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_fall = r_sclk_prev & ~w_sclk_s;

  // The final bit is still on w_mosi_s when the frame completes, so it is appended here.
  assign w_frame    = {w_mosi_s, r_frame};
  assign w_op       = w_frame[7:0];
  assign w_op_vld   = (w_op == 8'h01) || (w_op == 8'h02);
  assign w_last_bit = w_sclk_fall & ~w_cs_s & (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
  assign w_start    = w_last_bit & w_op_vld & (r_state == S_IDLE);

  assign start_flag = r_start;
  assign data_adr_o = r_adr & 32'hFFFF_FFFC;
  assign miso       = ~w_cs_s & r_tx[0];

  // Synchronise the SPI pins into clk and remember last sclk for edge detection.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_sclk_prev <= w_sclk_s;
    end
  end

  // Receive shifter: bits enter at the top so bit k lands at index k; counter saturates past the frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_bit_cnt <= '0;
      r_frame   <= '0;
    end else if (w_cs_s) begin
      r_bit_cnt <= '0;
    end else if (w_sclk_fall && (r_bit_cnt != CNT_W'(FRAME_BITS))) begin
      r_bit_cnt <= r_bit_cnt + 1'b1;
      r_frame   <= {w_mosi_s, r_frame[FRAME_BITS-2:1]};
    end
  end

  // Transmit shifter: reload from the read buffer until the first bit of a frame, then shift out LSB first.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_tx <= '0;
    end else if (!w_cs_s) begin
      if (w_sclk_fall) begin
        r_tx <= {1'b0, r_tx[31:1]};
      end else if (r_bit_cnt == '0) begin
        r_tx <= r_rd_buf;
      end
    end
  end

  // Latch the decoded command when a frame is accepted; pulse start_flag alongside.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_is_rd <= 1'b0;
      r_adr   <= '0;
      r_wdat  <= '0;
      r_start <= 1'b0;
    end else begin
      r_start <= w_start;
      if (w_start) begin
        r_is_rd <= (w_op == 8'h02);
        r_adr   <= w_frame[39:8];
        r_wdat  <= w_frame[FRAME_BITS-1:40];
      end
    end
  end

  // Read buffer holds the last read response until the next read ack.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rd_buf <= '0;
    end else if (w_capture) begin
      r_rd_buf <= data_rd_i;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state and TCM request outputs; an ack may coincide with the accept.
  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    mem_d_rd_o   = 1'b0;
    data_wr_en_o = 4'h0;
    data_wr_o    = 32'h0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        mem_d_rd_o = r_is_rd;
        if (!r_is_rd) begin
          data_wr_en_o = 4'hF;
          data_wr_o    = r_wdat;
        end
        if (mem_accept) begin
          if (mem_ack) begin
            w_capture   = r_is_rd;
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          w_capture   = r_is_rd;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Bench for spi_mem_slave: directed SPI frames against a small TCM model.
// Expectations are queued at stimulus time; monitors pop and compare on DUT activity.
// TCM accept is steerable to exercise stalls.
module tb_spi_mem_slave;

  logic        clk = 1'b0;
  logic        rstn;
  logic        sclk;
  logic        cs;
  logic        mosi;
  logic        miso;
  logic        start_flag;
  logic [31:0] data_rd_i;
  logic        mem_d_rd_o;
  logic [31:0] data_adr_o;
  logic [31:0] data_wr_o;
  logic [3:0]  data_wr_en_o;
  logic        mem_ack;
  logic        mem_accept;
  logic        accept_en;

  always #5 clk = ~clk;
  assign mem_accept = accept_en;

  spi_mem_slave #(.FRAME_BITS(72), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .sclk         (sclk),
    .cs           (cs),
    .mosi         (mosi),
    .miso         (miso),
    .start_flag   (start_flag),
    .data_rd_i    (data_rd_i),
    .mem_d_rd_o   (mem_d_rd_o),
    .data_adr_o   (data_adr_o),
    .data_wr_o    (data_wr_o),
    .data_wr_en_o (data_wr_en_o),
    .mem_ack      (mem_ack),
    .mem_accept   (mem_accept)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        rd;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_start_q[$];
  logic [31:0] exp_miso_q[$];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // TCM model: accepts whenever accept_en, acks one cycle later.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem_ack   <= 1'b0;
      data_rd_i <= 32'h0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_accept) begin
        if (|data_wr_en_o) begin
          mem[data_adr_o[7:2]] <= data_wr_o;
          mem_ack <= 1'b1;
        end else if (mem_d_rd_o) begin
          data_rd_i <= mem[data_adr_o[7:2]];
          mem_ack   <= 1'b1;
        end
      end
    end
  end

  // Monitor: TCM requests, stability while stalled, and match against expected queue.
  logic        prev_pend = 1'b0;
  logic [68:0] prev_snap = '0;
  logic [68:0] snap;
  logic        req_now;
  req_t        er;
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      req_now = mem_d_rd_o | (|data_wr_en_o);
      snap    = {mem_d_rd_o, data_wr_en_o, data_adr_o, data_wr_o};
      if (prev_pend) check("req_stable", 80'(snap), 80'(prev_snap));
      if (req_now && mem_accept) begin
        if (exp_req_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL req_unexpected: got request at adr %0h expected none", data_adr_o);
        end else begin
          er = exp_req_q.pop_front();
          check("req_kind", 80'({mem_d_rd_o, data_wr_en_o}), 80'({er.rd, (er.rd ? 4'h0 : 4'hF)}));
          check("req_adr", 80'(data_adr_o), 80'(er.adr));
          if (!er.rd) check("req_wdat", 80'(data_wr_o), 80'(er.dat));
        end
      end
      prev_pend = req_now && !mem_accept;
      prev_snap = snap;
    end
  end

  // Monitor: start_flag pulses, one clk wide, with the latched address.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      if (start_flag) begin
        check("start_prev_low", 80'(prev_start), 80'(0));
        if (exp_start_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL start_unexpected: got start_flag at adr %0h expected none", data_adr_o);
        end else begin
          check("start_adr", 80'(data_adr_o), 80'(exp_start_q.pop_front()));
        end
      end
      prev_start = start_flag;
    end
  end

  // Monitor: miso sampled at each sclk rise, compared per frame when cs rises.
  logic [79:0] cap = '0;
  int          nb  = 0;
  logic [31:0] em;
  always @(posedge sclk or posedge cs) begin
    if (cs === 1'b1) begin
      if (nb > 0) begin
        if (exp_miso_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL miso_unexpected: got frame of %0d bits expected none", nb);
        end else begin
          em = exp_miso_q.pop_front();
          check("miso_word", 80'(cap[31:0]), 80'(em));
          if (nb > 32) check("miso_tail_zero", cap >> 32, 80'(0));
        end
      end
      nb  = 0;
      cap = '0;
    end else begin
      cap[nb] = miso;
      nb++;
    end
  end

  function automatic logic [79:0] mkf(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    return {8'hFF, d, a, op};
  endfunction

  // Drives one frame of nbits (bits past 72 are 1s); mosi changes mid high phase.
  task automatic spi_frame(input logic [79:0] fr, input int nbits, input logic [31:0] exp_miso);
    exp_miso_q.push_back(exp_miso);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      sclk = 1'b1;
      repeat (2) @(negedge clk);
      mosi = fr[k];
      repeat (2) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    cs   = 1'b1;
    mosi = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rstn      = 1'b0;
    cs        = 1'b1;
    sclk      = 1'b0;
    mosi      = 1'b0;
    accept_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_miso", 80'(miso), 80'(0));
    check("rst_start", 80'(start_flag), 80'(0));
    check("rst_rd", 80'(mem_d_rd_o), 80'(0));
    check("rst_wr_en", 80'(data_wr_en_o), 80'(0));
    check("rst_adr", 80'(data_adr_o), 80'(0));
    check("rst_wdat", 80'(data_wr_o), 80'(0));
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0x10 <= DEADBEEF.
    exp_start_q.push_back(32'h10);
    exp_req_q.push_back('{rd: 1'b0, adr: 32'h10, dat: 32'hDEADBEEF});
    spi_frame(mkf(8'h01, 32'h10, 32'hDEADBEEF), 72, 32'h0);

    // Read 0x10 with a 73rd bit that must be ignored.
    exp_start_q.push_back(32'h10);
    exp_req_q.push_back('{rd: 1'b1, adr: 32'h10, dat: 32'h0});
    spi_frame(mkf(8'h02, 32'h10, 32'h0), 73, 32'h0);

    // No-op frame returns the read data on miso.
    spi_frame(mkf(8'h00, 32'h44, 32'h5555AAAA), 72, 32'hDEADBEEF);

    // Aborted write after 40 bits, then a full write to an unaligned address.
    spi_frame(mkf(8'h01, 32'h20, 32'h12345678), 40, 32'hDEADBEEF);
    exp_start_q.push_back(32'h24);
    exp_req_q.push_back('{rd: 1'b0, adr: 32'h24, dat: 32'hCAFEF00D});
    spi_frame(mkf(8'h01, 32'h27, 32'hCAFEF00D), 72, 32'hDEADBEEF);

    // Stall: read 0x24 waits for accept; a write completing meanwhile is dropped.
    accept_en = 1'b0;
    exp_start_q.push_back(32'h24);
    exp_req_q.push_back('{rd: 1'b1, adr: 32'h24, dat: 32'h0});
    spi_frame(mkf(8'h02, 32'h24, 32'h0), 72, 32'hDEADBEEF);
    spi_frame(mkf(8'h01, 32'h30, 32'h0BADF00D), 72, 32'hDEADBEEF);
    repeat (5) @(negedge clk);
    accept_en = 1'b1;
    repeat (10) @(negedge clk);

    // Unknown opcode: dropped, shifts out the stalled read's data.
    spi_frame(mkf(8'h7E, 32'h0, 32'h0), 72, 32'hCAFEF00D);
    repeat (20) @(negedge clk);

    check("mem_10", 80'(mem[6'h04]), 80'(32'hDEADBEEF));
    check("mem_24", 80'(mem[6'h09]), 80'(32'hCAFEF00D));
    check("mem_20_untouched", 80'(mem[6'h08]), 80'(32'h0));
    check("mem_30_untouched", 80'(mem[6'h0C]), 80'(32'h0));
    check("req_q_left", 80'(exp_req_q.size()), 80'(0));
    check("start_q_left", 80'(exp_start_q.size()), 80'(0));
    check("miso_q_left", 80'(exp_miso_q.size()), 80'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
